atm_txn_arbiter: RTL and testbench

- Shares one ATM core between NUM_REQ transaction requesters (terminals or bench drivers).
- Latches one requester's transaction and launches it on the core by releasing core_rst.
- Detects completion or timeout, returns the core's balance/success to the winner, then re-arms the core.
- Sits directly above the ATM core; the core's ports map one-to-one onto the core_* ports below.

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_txn_arbiter_if.sv | 33 +++
 rtl/atm_rr_picker.sv | 50 +++++
 rtl/atm_txn_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_atm_txn_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction arbiter and its round-robin picker:
// field widths, operation codes, core state encodings and the arbiter state enum.
package atm_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ACC_W  = 4;
  localparam int unsigned DATA_W = 14;

  localparam logic [OP_W-1:0] OP_BALANCE    = 3'd1;
  localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd2;
  localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd3;
  localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd4;

  localparam logic [2:0] CORE_IDLE   = 3'd0;
  localparam logic [2:0] CORE_AUTH   = 3'd1;
  localparam logic [2:0] CORE_EXEC   = 3'd2;
  localparam logic [2:0] CORE_RESULT = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/atm_txn_arbiter_if.sv
// Requester-side bundle of the ATM transaction arbiter: packed request fields in,
// grant / response pulses and held results out.
interface atm_txn_arbiter_if
  import atm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic [ACC_W*NUM_REQ-1:0]  req_acc;
  logic [DATA_W*NUM_REQ-1:0] req_pin;
  logic [DATA_W*NUM_REQ-1:0] req_new_pin;
  logic [DATA_W*NUM_REQ-1:0] req_amount;
  logic [NUM_REQ-1:0]        req_lang;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_balance;
  logic                      resp_success;
  logic                      resp_timeout;
  logic                      busy;

  modport master (
    output req, req_op, req_acc, req_pin, req_new_pin, req_amount, req_lang,
    input  gnt, resp_valid, resp_balance, resp_success, resp_timeout, busy
  );

  modport slave (
    input  req, req_op, req_acc, req_pin, req_new_pin, req_amount, req_lang,
    output gnt, resp_valid, resp_balance, resp_success, resp_timeout, busy
  );

endinterface

// File: rtl/atm_rr_picker.sv
// Combinational round-robin winner selection starting at ptr, wrapping modulo NUM_REQ.
// With ATM_ARB_PRIO0_EN defined, requester 0 overrides the rotation whenever it asks.
module atm_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       win_vld
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] cand;
  logic               found;

  always_comb begin
    cand    = req;
    found   = 1'b0;
    win_idx = '0;
    win_oh  = '0;
`ifdef ATM_ARB_PRIO0_EN
    if (req[0]) begin
      found = 1'b1;
    end
    cand[0] = 1'b0;
`endif
    // Wrap search split into two constant-index passes: [ptr..N-1] then [0..ptr-1].
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i] && (IDX_W'(i) >= ptr)) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i] && (IDX_W'(i) < ptr)) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && (win_idx == IDX_W'(i))) begin
        win_oh[i] = 1'b1;
      end
    end
    win_vld = found;
  end

endmodule

// File: rtl/atm_txn_arbiter.sv
// Shares one ATM core among NUM_REQ requesters: latch winner's fields, run the core,
// return balance/success or a timeout. Optional macro ATM_ARB_PRIO0_EN gives requester 0 priority.
module atm_txn_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MIN_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 15,
  parameter logic [2:0]  IDLE_CODE  = CORE_IDLE
) (
  input  logic              clk,
  input  logic              rst,
  atm_txn_arbiter_if.slave  req_if,
  output logic              core_rst,
  output logic [OP_W-1:0]   core_operation,
  output logic [ACC_W-1:0]  core_acc_num,
  output logic [DATA_W-1:0] core_pin,
  output logic [DATA_W-1:0] core_new_pin,
  output logic [DATA_W-1:0] core_amount,
  output logic              core_language,
  input  logic [DATA_W-1:0] core_balance,
  input  logic              core_success,
  input  logic [2:0]        core_state
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned TIMER_W = $clog2(MAX_CYCLES + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [TIMER_W-1:0] MIN_T    = TIMER_W'(MIN_CYCLES);
  localparam logic [TIMER_W-1:0] MAX_T    = TIMER_W'(MAX_CYCLES);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]  win_oh_q, win_oh_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_balance_q, resp_balance_d;
  logic                resp_success_q, resp_success_d;
  logic                resp_timeout_q, resp_timeout_d;
  logic                busy_q, busy_d;
  logic                core_rst_q, core_rst_d;
  logic [OP_W-1:0]     core_op_q, core_op_d;
  logic [ACC_W-1:0]    core_acc_q, core_acc_d;
  logic [DATA_W-1:0]   core_pin_q, core_pin_d;
  logic [DATA_W-1:0]   core_new_pin_q, core_new_pin_d;
  logic [DATA_W-1:0]   core_amount_q, core_amount_d;
  logic                core_lang_q, core_lang_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic                complete;
  logic                expired;

  atm_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req_if.req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    win_idx_d      = win_idx_q;
    win_oh_d       = win_oh_q;
    timer_d        = timer_q;
    gnt_d          = '0;
    resp_valid_d   = '0;
    resp_balance_d = resp_balance_q;
    resp_success_d = resp_success_q;
    resp_timeout_d = resp_timeout_q;
    core_op_d      = core_op_q;
    core_acc_d     = core_acc_q;
    core_pin_d     = core_pin_q;
    core_new_pin_d = core_new_pin_q;
    core_amount_d  = core_amount_q;
    core_lang_d    = core_lang_q;
    complete       = (timer_q >= MIN_T) && (core_state == IDLE_CODE);
    expired        = (timer_q == MAX_T);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_idx_d = pick_idx;
          win_oh_d  = pick_oh;
          gnt_d     = pick_oh;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
              core_op_d      = req_if.req_op[i*OP_W +: OP_W];
              core_acc_d     = req_if.req_acc[i*ACC_W +: ACC_W];
              core_pin_d     = req_if.req_pin[i*DATA_W +: DATA_W];
              core_new_pin_d = req_if.req_new_pin[i*DATA_W +: DATA_W];
              core_amount_d  = req_if.req_amount[i*DATA_W +: DATA_W];
              core_lang_d    = req_if.req_lang[i];
            end
          end
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        timer_d = timer_q + 1'b1;
        // Results are registered on the RUN->DONE edge so resp_valid is visible during DONE,
        // while the core is still out of reset and its outputs are meaningful.
        if (complete || expired) begin
          resp_balance_d = core_balance;
          resp_success_d = complete ? core_success : 1'b0;
          resp_timeout_d = !complete;
          resp_valid_d   = win_oh_q;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef ATM_ARB_PRIO0_EN
        if (win_idx_q != '0) begin
          ptr_d = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
        end
`else
        ptr_d = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    core_rst_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      win_idx_q      <= '0;
      win_oh_q       <= '0;
      timer_q        <= '0;
      gnt_q          <= '0;
      resp_valid_q   <= '0;
      resp_balance_q <= '0;
      resp_success_q <= 1'b0;
      resp_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
      core_rst_q     <= 1'b1;
      core_op_q      <= '0;
      core_acc_q     <= '0;
      core_pin_q     <= '0;
      core_new_pin_q <= '0;
      core_amount_q  <= '0;
      core_lang_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      win_idx_q      <= win_idx_d;
      win_oh_q       <= win_oh_d;
      timer_q        <= timer_d;
      gnt_q          <= gnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_balance_q <= resp_balance_d;
      resp_success_q <= resp_success_d;
      resp_timeout_q <= resp_timeout_d;
      busy_q         <= busy_d;
      core_rst_q     <= core_rst_d;
      core_op_q      <= core_op_d;
      core_acc_q     <= core_acc_d;
      core_pin_q     <= core_pin_d;
      core_new_pin_q <= core_new_pin_d;
      core_amount_q  <= core_amount_d;
      core_lang_q    <= core_lang_d;
    end
  end

  assign req_if.gnt          = gnt_q;
  assign req_if.resp_valid   = resp_valid_q;
  assign req_if.resp_balance = resp_balance_q;
  assign req_if.resp_success = resp_success_q;
  assign req_if.resp_timeout = resp_timeout_q;
  assign req_if.busy         = busy_q;

  assign core_rst       = core_rst_q;
  assign core_operation = core_op_q;
  assign core_acc_num   = core_acc_q;
  assign core_pin       = core_pin_q;
  assign core_new_pin   = core_new_pin_q;
  assign core_amount    = core_amount_q;
  assign core_language  = core_lang_q;

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Directed bench for atm_txn_arbiter: a vector table of transactions plus hand-written
// mid-flight reset and field-change sequences, against a simple counting core model.
`timescale 1ns/1ps
module tb_atm_txn_arbiter;
  import atm_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MINC = 2;
  localparam int unsigned MAXC = 15;
`ifdef ATM_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rst;
  logic [2:0]  core_operation;
  logic [3:0]  core_acc_num;
  logic [13:0] core_pin, core_new_pin, core_amount;
  logic        core_language;
  logic [13:0] core_balance = '0;
  logic        core_success = 1'b0;
  logic [2:0]  core_state;

  always #5 clk = ~clk;

  atm_txn_arbiter_if #(.NUM_REQ(N)) bus ();

  atm_txn_arbiter #(
    .NUM_REQ(N), .MIN_CYCLES(MINC), .MAX_CYCLES(MAXC), .IDLE_CODE(3'd0)
  ) dut (
    .clk(clk), .rst(rst), .req_if(bus),
    .core_rst(core_rst), .core_operation(core_operation), .core_acc_num(core_acc_num),
    .core_pin(core_pin), .core_new_pin(core_new_pin), .core_amount(core_amount),
    .core_language(core_language), .core_balance(core_balance),
    .core_success(core_success), .core_state(core_state)
  );

  // Core model: leaves idle after reset release, returns to idle once cnt exceeds done_t.
  int unsigned cnt = 0;
  int unsigned done_t = 2;
  logic        hang = 1'b0;
  always @(posedge clk) cnt <= core_rst ? 0 : cnt + 1;
  assign core_state = core_rst ? 3'd0 : (hang ? 3'd2 : ((cnt > done_t) ? 3'd0 : 3'd1));

  logic [2:0]  f_op[N];
  logic [3:0]  f_acc[N];
  logic [13:0] f_pin[N], f_new_pin[N], f_amount[N];
  logic        f_lang[N];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_fields();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_op[i*3 +: 3]        = f_op[i];
      bus.req_acc[i*4 +: 4]       = f_acc[i];
      bus.req_pin[i*14 +: 14]     = f_pin[i];
      bus.req_new_pin[i*14 +: 14] = f_new_pin[i];
      bus.req_amount[i*14 +: 14]  = f_amount[i];
      bus.req_lang[i]             = f_lang[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output int unsigned waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.gnt == '0 && waited < 20);
  endtask

  task automatic run_txn(input logic [N-1:0] r, input int unsigned dt, input logic hg,
                         input logic [13:0] bal, input logic sc, input int unsigned exp_g,
                         input logic [13:0] exp_bal, input logic exp_s, input logic exp_to);
    int unsigned waited;
    int unsigned lat;
    logic [N-1:0] exp_oh;
    int unsigned exp_lat;
    exp_oh  = N'(1 << exp_g);
    exp_lat = hg ? MAXC + 2 : ((dt < MINC) ? MINC : dt) + 2;
    done_t = dt; hang = hg; core_balance = bal; core_success = sc;
    @(negedge clk);
    bus.req = r;
    wait_gnt(waited);
    check("gnt_onehot", 32'(bus.gnt), 32'(exp_oh));
    bus.req = '0;
    check("busy_in_gnt", 32'(bus.busy), 32'd1);
    check("core_rst_launch", 32'(core_rst), 32'd0);
    check("core_op", 32'(core_operation), 32'(f_op[exp_g]));
    check("core_acc", 32'(core_acc_num), 32'(f_acc[exp_g]));
    check("core_pin", 32'(core_pin), 32'(f_pin[exp_g]));
    check("core_new_pin", 32'(core_new_pin), 32'(f_new_pin[exp_g]));
    check("core_amount", 32'(core_amount), 32'(f_amount[exp_g]));
    check("core_lang", 32'(core_language), 32'(f_lang[exp_g]));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("gnt_pulse", 32'(bus.gnt), 32'd0);
    end while (bus.resp_valid == '0 && lat < 40);
    check("resp_latency", lat, exp_lat);
    check("resp_valid", 32'(bus.resp_valid), 32'(exp_oh));
    check("resp_balance", 32'(bus.resp_balance), 32'(exp_bal));
    check("resp_success", 32'(bus.resp_success), 32'(exp_s));
    check("resp_timeout", 32'(bus.resp_timeout), 32'(exp_to));
    check("core_rst_done", 32'(core_rst), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("resp_pulse", 32'(bus.resp_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("resp_hold", 32'(bus.resp_balance), 32'(exp_bal));
  endtask

  typedef struct {
    logic         rst_before;
    logic [N-1:0] req;
    int unsigned  dt;
    logic         hg;
    logic [13:0]  bal;
    logic         sc;
    logic [13:0]  exp_bal;
    logic         exp_s;
    logic         exp_to;
    int unsigned  g_rr;
    int unsigned  g_p0;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned waited;
    int unsigned seen;
    f_op      = '{3'd1, 3'd2, 3'd3, 3'd4};
    f_acc     = '{4'd4, 4'd7, 4'd5, 4'd12};
    f_pin     = '{14'd1111, 14'd2222, 14'd3333, 14'd4444};
    f_new_pin = '{14'd5000, 14'd6000, 14'd7000, 14'd8000};
    f_amount  = '{14'd50, 14'd75, 14'd100, 14'd125};
    f_lang    = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.req = '0;
    pack_fields();

    //            rst   req      dt hg    bal      sc    exp_bal  s     to    rr p0
    vecs[0]  = '{1'b1, 4'b0100, 3, 1'b0, 14'd900, 1'b1, 14'd900, 1'b1, 1'b0, 2, 2};
    vecs[1]  = '{1'b1, 4'b1111, 2, 1'b0, 14'd10,  1'b0, 14'd10,  1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 4'b1111, 4, 1'b0, 14'd20,  1'b1, 14'd20,  1'b1, 1'b0, 1, 0};
    vecs[3]  = '{1'b0, 4'b1111, 5, 1'b0, 14'd30,  1'b1, 14'd30,  1'b1, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 4'b1111, 2, 1'b0, 14'd40,  1'b0, 14'd40,  1'b0, 1'b0, 3, 0};
    vecs[5]  = '{1'b0, 4'b1111, 3, 1'b0, 14'd50,  1'b1, 14'd50,  1'b1, 1'b0, 0, 0};
    vecs[6]  = '{1'b0, 4'b1000, 2, 1'b1, 14'd60,  1'b1, 14'd60,  1'b0, 1'b1, 3, 3};
    vecs[7]  = '{1'b1, 4'b1011, 1, 1'b0, 14'd70,  1'b1, 14'd70,  1'b1, 1'b0, 0, 0};
    vecs[8]  = '{1'b0, 4'b1010, 2, 1'b0, 14'd80,  1'b1, 14'd80,  1'b1, 1'b0, 1, 1};
    vecs[9]  = '{1'b0, 4'b1011, 3, 1'b0, 14'd90,  1'b0, 14'd90,  1'b0, 1'b0, 3, 0};
    vecs[10] = '{1'b0, 4'b1010, 2, 1'b0, 14'd100, 1'b1, 14'd100, 1'b1, 1'b0, 1, 3};

    do_reset();
    @(negedge clk);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_balance", 32'(bus.resp_balance), 32'd0);
    check("rst_core_amount", 32'(core_amount), 32'd0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst_before) do_reset();
      run_txn(vecs[v].req, vecs[v].dt, vecs[v].hg, vecs[v].bal, vecs[v].sc,
              PRIO ? vecs[v].g_p0 : vecs[v].g_rr,
              vecs[v].exp_bal, vecs[v].exp_s, vecs[v].exp_to);
    end

    // Reset two cycles into RUN drops the transaction and the pointer.
    hang = 1'b1;
    @(negedge clk);
    bus.req = 4'b0100;
    wait_gnt(waited);
    check("mid_rst_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_core_op", 32'(core_operation), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen++;
    end
    check("mid_rst_no_resp", seen, 32'd0);

    // Requester 1's amount changes while its transaction runs.
    hang = 1'b0; done_t = 4; core_balance = 14'd222; core_success = 1'b1;
    f_amount[1] = 14'd321;
    pack_fields();
    bus.req = 4'b0110;
    wait_gnt(waited);
    check("ptr_after_rst_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    check("latched_amount", 32'(core_amount), 32'd321);
    repeat (2) @(negedge clk);
    f_amount[1] = 14'd77;
    pack_fields();
    repeat (2) @(negedge clk);
    check("amount_stable_run", 32'(core_amount), 32'd321);
    seen = 0;
    while (bus.resp_valid == '0 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("midflight_resp", 32'(bus.resp_valid), 32'b0010);
    check("midflight_amount_at_done", 32'(core_amount), 32'd321);
    run_txn(4'b0010, 2, 1'b0, 14'd5, 1'b1, 1, 14'd5, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
